// File: rtl/mult_issue_if.sv
// -----------------------------------------------------------------------------
// mult_issue_if
// Stream bundle between the caller and mult_issue_ctrl.
//   in_*  : operand pair upstream handshake (valid/ready, two operands, tag)
//   out_* : result downstream handshake (valid/ready, product, tag, latency)
// master : the caller side (drives operands, consumes results)
// slave  : the controller side
// -----------------------------------------------------------------------------
interface mult_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_mlier;
    logic [31:0] in_mcand;
    logic [3:0]  in_tag;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_prodt;
    logic [3:0]  out_tag;
    logic [7:0]  out_latency;

    modport master (
        output in_valid, in_mlier, in_mcand, in_tag, out_ready,
        input  in_ready, out_valid, out_prodt, out_tag, out_latency
    );

    modport slave (
        input  in_valid, in_mlier, in_mcand, in_tag, out_ready,
        output in_ready, out_valid, out_prodt, out_tag, out_latency
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mult_issue_ctrl
// Buffers signed 32x32 operand pairs in a small FIFO and issues them one at a
// time to an external multiplier that captures operands on a rising m_start.
// The product is returned through a single result register together with the
// caller tag and the number of BUSY cycles the multiplier took. An operation
// that runs TIMEOUT BUSY cycles without m_valid is dropped and a sticky
// timeout_err is raised.
//
// Ports:
//   clock        rising-edge clock
//   reset        asynchronous, active-high reset
//   bus          mult_issue_if.slave (operand input stream, result output stream)
//   m_start      multiplier start, high for the whole BUSY state
//   m_mlier      multiplier operand, held after the operation ends
//   m_mcand      multiplicand operand, held after the operation ends
//   m_prodt      product from the multiplier, valid when m_valid=1
//   m_valid      one-cycle completion pulse from the multiplier
//   timeout_err  sticky abort flag, cleared only by reset
// -----------------------------------------------------------------------------
module mult_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    mult_issue_if.slave bus,
    output logic        m_start,
    output logic [31:0] m_mlier,
    output logic [31:0] m_mcand,
    input  logic [63:0] m_prodt,
    input  logic        m_valid,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
    localparam logic [CW-1:0] EMPTY_C    = {CW{1'b0}};
    localparam logic [7:0]    TIMEOUT_C  = 8'(TIMEOUT);
    localparam logic [7:0]    GAP_LAST_C = 8'(GAP - 1);
    localparam logic [7:0]    LAT_MAX_C  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAPW = 2'd2
    } state_t;

    // Latency counter increment that sticks at its maximum value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == LAT_MAX_C) begin
            r = v;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    // FIFO storage and control
    logic [31:0]   fifo_mlier_r [DEPTH];
    logic [31:0]   fifo_mcand_r [DEPTH];
    logic [3:0]    fifo_tag_r   [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic          in_ready_r;

    // Issue FSM and operation context
    state_t        state_r;
    state_t        state_nxt_s;
    logic [7:0]    lat_cnt_r;
    logic [7:0]    gap_cnt_r;
    logic [3:0]    tag_r;
    logic          m_start_r;
    logic [31:0]   m_mlier_r;
    logic [31:0]   m_mcand_r;

    // Result register
    logic          out_valid_r;
    logic [63:0]   out_prodt_r;
    logic [3:0]    out_tag_r;
    logic [7:0]    out_latency_r;
    logic          timeout_err_r;

    // Decoded events
    logic          push_s;
    logic          issue_s;
    logic          capture_s;
    logic          abort_s;
    logic          release_s;

    // Decode the per-cycle events from the handshakes and the FSM state.
    always_comb begin
        push_s    = bus.in_valid && in_ready_r;
        issue_s   = (state_r == ST_IDLE) && (count_r != EMPTY_C) && !out_valid_r;
        capture_s = (state_r == ST_BUSY) && m_valid;
        // A completion in the timeout cycle takes priority over the abort.
        abort_s   = (state_r == ST_BUSY) && !m_valid && (lat_cnt_r == TIMEOUT_C);
        release_s = out_valid_r && bus.out_ready;
    end

    // Next FIFO occupancy.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !issue_s) begin
            count_nxt_s = count_r + CW'(1'b1);
        end else if (!push_s && issue_s) begin
            count_nxt_s = count_r - CW'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Issue FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (capture_s || abort_s) begin
                    state_nxt_s = ST_GAPW;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_GAPW: begin
                if (gap_cnt_r == GAP_LAST_C) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_GAPW;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO storage, pointers and registered ready (ready depends only on the
    // current occupancy, so a same-cycle pop never frees room for a push).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mlier_r[i] <= 32'd0;
                fifo_mcand_r[i] <= 32'd0;
                fifo_tag_r[i]   <= 4'd0;
            end
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= EMPTY_C;
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mlier_r[wr_ptr_r] <= bus.in_mlier;
                fifo_mcand_r[wr_ptr_r] <= bus.in_mcand;
                fifo_tag_r[wr_ptr_r]   <= bus.in_tag;
                wr_ptr_r               <= wr_ptr_r + AW'(1'b1);
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != FULL_C);
        end
    end

    // FSM state, operand registers, BUSY latency and GAPW counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            m_start_r <= 1'b0;
            m_mlier_r <= 32'd0;
            m_mcand_r <= 32'd0;
            tag_r     <= 4'd0;
            lat_cnt_r <= 8'd0;
            gap_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            // m_start mirrors the BUSY state, so it drops on leaving BUSY and
            // every issue produces a fresh rising edge.
            m_start_r <= (state_nxt_s == ST_BUSY);
            if (issue_s) begin
                m_mlier_r <= fifo_mlier_r[rd_ptr_r];
                m_mcand_r <= fifo_mcand_r[rd_ptr_r];
                tag_r     <= fifo_tag_r[rd_ptr_r];
                lat_cnt_r <= 8'd1;
            end else if (state_r == ST_BUSY) begin
                lat_cnt_r <= sat_inc8(lat_cnt_r);
            end else begin
                lat_cnt_r <= lat_cnt_r;
            end
            if (state_r == ST_BUSY) begin
                gap_cnt_r <= 8'd0;
            end else if (state_r == ST_GAPW) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end
    end

    // Result register and sticky timeout flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_r   <= 1'b0;
            out_prodt_r   <= 64'd0;
            out_tag_r     <= 4'd0;
            out_latency_r <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            // Capture and release cannot coincide: issue needs an empty register.
            if (capture_s) begin
                out_valid_r   <= 1'b1;
                out_prodt_r   <= m_prodt;
                out_tag_r     <= tag_r;
                out_latency_r <= lat_cnt_r;
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (abort_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_prodt   = out_prodt_r;
    assign bus.out_tag     = out_tag_r;
    assign bus.out_latency = out_latency_r;
    assign m_start         = m_start_r;
    assign m_mlier         = m_mlier_r;
    assign m_mcand         = m_mcand_r;
    assign timeout_err     = timeout_err_r;

endmodule
